// File: rtl/tc_switch_arbiter.sv
// Round-robin registered switch: CHANNELS gated requesters share one BIT_WIDTH output bus.
// Optional macro TC_SWITCH_ARBITER_HOLD_EN: idle cycles keep the last granted data on out.
module tc_switch_arbiter #(
    parameter int UUID      = 0,
    parameter     NAME      = "",
    parameter int BIT_WIDTH = 1,
    parameter int CHANNELS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           en,
    input  logic [CHANNELS*BIT_WIDTH-1:0] in,
    output logic [BIT_WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]           grant,
    output logic                          valid,
    output logic                          conflict
);
    localparam int PTR_W = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(CHANNELS + 1);

    if (BIT_WIDTH < 1 || CHANNELS < 2 || CHANNELS > 16) begin : g_bad_cfg
        $error("tc_switch_arbiter %s (uuid %0d): unsupported BIT_WIDTH/CHANNELS", NAME, UUID);
    end

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [BIT_WIDTH-1:0] out_q, out_d;
    logic [CHANNELS-1:0]  grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic                 conflict_q, conflict_d;

    logic                 found_s;
    logic [PTR_W-1:0]     gnt_idx_s;
    logic [CNT_W-1:0]     req_cnt_s;
    logic [BIT_WIDTH-1:0] sel_data_s;

    // Channel index ofs places after base, wrapping at CHANNELS (not at 2**PTR_W).
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int ofs);
        int sum;
        sum = 32'(base) + ofs;
        if (sum >= CHANNELS) begin
            sum = sum - CHANNELS;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Cyclic scan from ptr_q for the first requester, plus request popcount.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = '0;
        req_cnt_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found_s && en[rr_index(ptr_q, k)]) begin
                found_s   = 1'b1;
                gnt_idx_s = rr_index(ptr_q, k);
            end else begin
                found_s   = found_s;
            end
            req_cnt_s = req_cnt_s + CNT_W'(en[k]);
        end
    end

    // Data mux: only the granted slice of in is ever looked at.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (32'(gnt_idx_s) == k) begin
                sel_data_s = in[k*BIT_WIDTH +: BIT_WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state for the output registers and the rotation pointer.
    always_comb begin
        ptr_d      = ptr_q;
        out_d      = out_q;
        grant_d    = '0;
        valid_d    = 1'b0;
        conflict_d = 1'b0;
        if (found_s) begin
            out_d              = sel_data_s;
            grant_d[gnt_idx_s] = 1'b1;
            valid_d            = 1'b1;
            conflict_d         = (req_cnt_s > CNT_W'(1));
            if (gnt_idx_s == PTR_W'(CHANNELS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + PTR_W'(1);
            end
        end else begin
`ifdef TC_SWITCH_ARBITER_HOLD_EN
            out_d = out_q;
`else
            out_d = '0;
`endif
        end
    end

    // State and output registers; reset also forgets rotation history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            out_q      <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            out_q      <= out_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end

    assign out      = out_q;
    assign grant    = grant_q;
    assign valid    = valid_q;
    assign conflict = conflict_q;
endmodule

// File: tb/tb_tc_switch_arbiter.sv
// Directed bench for tc_switch_arbiter: a 4-channel and a 3-channel instance, 8-bit data.
module tb_tc_switch_arbiter;
    logic        clk;
    logic        rst4, rst3;
    logic [3:0]  en4;
    logic [2:0]  en3;
    logic [31:0] in4;
    logic [23:0] in3;
    logic [7:0]  out4, out3;
    logic [3:0]  grant4;
    logic [2:0]  grant3;
    logic        valid4, valid3, conflict4, conflict3;
    int          n_assert;
    int          n_fail;
    logic [7:0]  idle_out;

    tc_switch_arbiter #(.UUID(1), .NAME("sw4"), .BIT_WIDTH(8), .CHANNELS(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .in(in4),
        .out(out4), .grant(grant4), .valid(valid4), .conflict(conflict4)
    );

    tc_switch_arbiter #(.UUID(2), .NAME("sw3"), .BIT_WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .in(in3),
        .out(out3), .grant(grant3), .valid(valid3), .conflict(conflict3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [7:0] eo, input logic [3:0] eg,
                          input logic ev, input logic ec);
        check({tag, ".out"},      32'(out4),      32'(eo));
        check({tag, ".grant"},    32'(grant4),    32'(eg));
        check({tag, ".valid"},    32'(valid4),    32'(ev));
        check({tag, ".conflict"}, 32'(conflict4), 32'(ec));
    endtask

    task automatic check3(input string tag, input logic [7:0] eo, input logic [2:0] eg,
                          input logic ev, input logic ec);
        check({tag, ".out"},      32'(out3),      32'(eo));
        check({tag, ".grant"},    32'(grant3),    32'(eg));
        check({tag, ".valid"},    32'(valid3),    32'(ev));
        check({tag, ".conflict"}, 32'(conflict3), 32'(ec));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
`ifdef TC_SWITCH_ARBITER_HOLD_EN
        idle_out = 8'h3C;
`else
        idle_out = 8'h00;
`endif
        rst4 = 1'b1; rst3 = 1'b1;
        en4  = 4'b1111; en3 = 3'b111;
        in4  = {8'h13, 8'h12, 8'h11, 8'h10};
        in3  = {8'h22, 8'h21, 8'h20};

        // Reset overrides full contention
        tick(); check4("rst_c1", 8'h00, 4'b0000, 1'b0, 1'b0);
        tick(); check4("rst_c2", 8'h00, 4'b0000, 1'b0, 1'b0);
        check3("rst3", 8'h00, 3'b000, 1'b0, 1'b0);

        // Rotation from reset
        rst4 = 1'b0;
        tick(); check4("rot0", 8'h10, 4'b0001, 1'b1, 1'b1);
        tick(); check4("rot1", 8'h11, 4'b0010, 1'b1, 1'b1);
        tick(); check4("rot2", 8'h12, 4'b0100, 1'b1, 1'b1);
        tick(); check4("rot3", 8'h13, 4'b1000, 1'b1, 1'b1);
        tick(); check4("rot4", 8'h10, 4'b0001, 1'b1, 1'b1);

        // Single request, ptr=1
        en4 = 4'b0010; in4[15:8] = 8'hA5;
        tick(); check4("single", 8'hA5, 4'b0010, 1'b1, 1'b0);

        // Grant channel 2 (ptr->3), then wrap past 3
        en4 = 4'b0100;
        tick(); check4("g2", 8'h12, 4'b0100, 1'b1, 1'b0);
        en4 = 4'b0101;
        tick(); check4("wrap", 8'h10, 4'b0001, 1'b1, 1'b1);
        tick(); check4("wrap2", 8'h12, 4'b0100, 1'b1, 1'b1);

        // Persistent single requester is never starved
        en4 = 4'b1000; in4[31:24] = 8'h3C;
        tick(); check4("pers0", 8'h3C, 4'b1000, 1'b1, 1'b0);
        tick(); check4("pers1", 8'h3C, 4'b1000, 1'b1, 1'b0);

        // Idle: ptr stays 0
        en4 = 4'b0000;
        tick(); check4("idle", idle_out, 4'b0000, 1'b0, 1'b0);
        en4 = 4'b0110;
        tick(); check4("after_idle", 8'hA5, 4'b0010, 1'b1, 1'b1);

        // Non-granted data ignored: change channel 1 data while 2 is granted
        en4 = 4'b0100; in4[15:8] = 8'hFF;
        tick(); check4("ignore", 8'h12, 4'b0100, 1'b1, 1'b0);

        // Three channels, explicit wrap from 2 to 0
        rst3 = 1'b0;
        tick(); check3("c3_0", 8'h20, 3'b001, 1'b1, 1'b1);
        tick(); check3("c3_1", 8'h21, 3'b010, 1'b1, 1'b1);
        tick(); check3("c3_2", 8'h22, 3'b100, 1'b1, 1'b1);
        tick(); check3("c3_3", 8'h20, 3'b001, 1'b1, 1'b1);
        tick(); check3("c3_4", 8'h21, 3'b010, 1'b1, 1'b1);

        // Reset mid-run discards ptr (was 2)
        rst3 = 1'b1;
        tick(); check3("c3_rst", 8'h00, 3'b000, 1'b0, 1'b0);
        rst3 = 1'b0;
        tick(); check3("c3_rel", 8'h20, 3'b001, 1'b1, 1'b1);
        en3 = 3'b100;
        tick(); check3("c3_single", 8'h22, 3'b100, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
